// File: rtl/tych_rx_frame_buf.sv
// Store-and-forward RX frame buffer: MAC beats land in a circular buffer and are
// released to the core only once the whole frame has arrived error-free.
module tych_rx_frame_buf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 512,
  parameter int ERR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_valid,
  input  logic [ERR_W-1:0]  rx_errors,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       cnt_frames_ok,
  output logic [31:0]       cnt_drop_err,
  output logic [31:0]       cnt_drop_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  logic [DATA_W+1:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] cnt_frames_ok_q, cnt_frames_ok_d;
  logic [31:0] cnt_drop_err_q, cnt_drop_err_d;
  logic [31:0] cnt_drop_ovf_q, cnt_drop_ovf_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic        out_valid_q, out_valid_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          start_frame;
  logic [AW:0]   base;
  logic          rd_en;

  // Write side: FSM, pointer rewind and drop/commit accounting
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    commit_ptr_d    = commit_ptr_q;
    cnt_frames_ok_d = cnt_frames_ok_q;
    cnt_drop_err_d  = cnt_drop_err_q;
    cnt_drop_ovf_d  = cnt_drop_ovf_q;
    wr_en           = 1'b0;
    wr_addr         = wr_ptr_q[AW-1:0];
    start_frame     = 1'b0;
    base            = wr_ptr_q;

    if (rx_valid) begin
      case (state_q)
        IDLE: start_frame = 1'b1;
        RECV: begin
          if (rx_sop) begin
            // Missing eop: drop the open frame and restart at the commit point.
            wr_ptr_d       = commit_ptr_q;
            cnt_drop_err_d = cnt_drop_err_d + 32'd1;
            start_frame    = 1'b1;
          end else if ((wr_ptr_q - rd_ptr_q) == PTR_FULL) begin
            wr_ptr_d       = commit_ptr_q;
            cnt_drop_ovf_d = cnt_drop_ovf_d + 32'd1;
            state_d        = rx_eop ? IDLE : DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rx_eop) begin
              state_d = IDLE;
              if (rx_errors == '0) begin
                commit_ptr_d    = wr_ptr_q + PTR_ONE;
                cnt_frames_ok_d = cnt_frames_ok_d + 32'd1;
              end else begin
                wr_ptr_d       = commit_ptr_q;
                cnt_drop_err_d = cnt_drop_err_d + 32'd1;
              end
            end
          end
        end
        DISCARD: begin
          if (rx_sop)      start_frame = 1'b1;
          else if (rx_eop) state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (start_frame) begin
        base = wr_ptr_d;
        if (!rx_sop) begin
          cnt_drop_err_d = cnt_drop_err_d + 32'd1;
          state_d        = rx_eop ? IDLE : DISCARD;
        end else if ((base - rd_ptr_q) == PTR_FULL) begin
          cnt_drop_ovf_d = cnt_drop_ovf_d + 32'd1;
          state_d        = rx_eop ? IDLE : DISCARD;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = base[AW-1:0];
          wr_ptr_d = base + PTR_ONE;
          state_d  = RECV;
          if (rx_eop) begin
            state_d = IDLE;
            if (rx_errors == '0) begin
              commit_ptr_d    = base + PTR_ONE;
              cnt_frames_ok_d = cnt_frames_ok_d + 32'd1;
            end else begin
              wr_ptr_d       = commit_ptr_q;
              cnt_drop_err_d = cnt_drop_err_d + 32'd1;
            end
          end
        end
      end
    end
  end

  // Read side: one-entry output register that never passes commit_ptr
  always_comb begin
    rd_en       = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || out_ready);
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_valid_d = out_valid_q;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      {out_eop_d, out_sop_d, out_data_d} = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {rx_eop, rx_sop, rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      commit_ptr_q    <= '0;
      rd_ptr_q        <= '0;
      cnt_frames_ok_q <= '0;
      cnt_drop_err_q  <= '0;
      cnt_drop_ovf_q  <= '0;
      out_data_q      <= '0;
      out_sop_q       <= 1'b0;
      out_eop_q       <= 1'b0;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      commit_ptr_q    <= commit_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_frames_ok_q <= cnt_frames_ok_d;
      cnt_drop_err_q  <= cnt_drop_err_d;
      cnt_drop_ovf_q  <= cnt_drop_ovf_d;
      out_data_q      <= out_data_d;
      out_sop_q       <= out_sop_d;
      out_eop_q       <= out_eop_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign out_valid     = out_valid_q;
  assign cnt_frames_ok = cnt_frames_ok_q;
  assign cnt_drop_err  = cnt_drop_err_q;
  assign cnt_drop_ovf  = cnt_drop_ovf_q;

endmodule

// File: tb/tb_tych_rx_frame_buf.sv
// Bench for tych_rx_frame_buf: queue-based frame model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tych_rx_frame_buf;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 512;
  localparam int ERR_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_sop, rx_eop, rx_valid;
  logic [ERR_W-1:0]  rx_errors;
  logic [DATA_W-1:0] out_data;
  logic              out_sop, out_eop, out_valid;
  logic              out_ready;
  logic [31:0]       cnt_frames_ok, cnt_drop_err, cnt_drop_ovf;

  int checks   = 0;
  int failures = 0;

  tych_rx_frame_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_valid(rx_valid), .rx_errors(rx_errors),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_frames_ok(cnt_frames_ok), .cnt_drop_err(cnt_drop_err),
    .cnt_drop_ovf(cnt_drop_ovf)
  );

  always #5 clk = ~clk;

  // Frame-level model: committed beats waiting to be read, beats of the open frame
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
  } beat_t;

  localparam int M_IDLE = 0, M_RECV = 1, M_DISC = 2;

  beat_t cq[$];
  beat_t pq[$];
  beat_t cur, rb;
  int    m_mode;
  int    n_c;
  bit    new_frame;
  logic  m_ov, m_s, m_e;
  logic [DATA_W-1:0] m_d;
  logic [31:0] m_ok, m_err, m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cq.delete(); pq.delete();
      m_mode = M_IDLE;
      m_ov = 1'b0; m_s = 1'b0; m_e = 1'b0; m_d = '0;
      m_ok = 0; m_err = 0; m_ovf = 0;
    end else begin
      n_c = cq.size();
      if (n_c > 0 && (!m_ov || out_ready)) begin
        rb = cq.pop_front();
        m_ov = 1'b1; m_d = rb.d; m_s = rb.s; m_e = rb.e;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (rx_valid) begin
        cur.d = rx_data; cur.s = rx_sop; cur.e = rx_eop;
        new_frame = 1'b0;
        if (m_mode == M_IDLE) begin
          new_frame = 1'b1;
        end else if (m_mode == M_RECV) begin
          if (rx_sop) begin
            pq.delete(); m_err++; new_frame = 1'b1;
          end else if (n_c + pq.size() == DEPTH) begin
            pq.delete(); m_ovf++; m_mode = rx_eop ? M_IDLE : M_DISC;
          end else begin
            pq.push_back(cur);
            if (rx_eop) begin
              m_mode = M_IDLE;
              if (rx_errors == 0) begin
                while (pq.size() > 0) cq.push_back(pq.pop_front());
                m_ok++;
              end else begin
                pq.delete(); m_err++;
              end
            end
          end
        end else begin
          if (rx_sop) new_frame = 1'b1;
          else if (rx_eop) m_mode = M_IDLE;
        end
        if (new_frame) begin
          if (!rx_sop) begin
            m_err++; m_mode = rx_eop ? M_IDLE : M_DISC;
          end else if (n_c == DEPTH) begin
            m_ovf++; m_mode = rx_eop ? M_IDLE : M_DISC;
          end else if (rx_eop) begin
            m_mode = M_IDLE;
            if (rx_errors == 0) begin cq.push_back(cur); m_ok++; end
            else m_err++;
          end else begin
            pq.push_back(cur); m_mode = M_RECV;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (out_valid !== m_ov || (m_ov && {out_sop, out_eop, out_data} !== {m_s, m_e, m_d})) begin
        failures++;
        $display("FAIL out_beat: got v=%b s=%b e=%b d=%h, want v=%b s=%b e=%b d=%h",
                 out_valid, out_sop, out_eop, out_data[31:0], m_ov, m_s, m_e, m_d[31:0]);
      end
      checks++;
      if ({cnt_frames_ok, cnt_drop_err, cnt_drop_ovf} !== {m_ok, m_err, m_ovf}) begin
        failures++;
        $display("FAIL counters: got ok=%0d err=%0d ovf=%0d, want ok=%0d err=%0d ovf=%0d",
                 cnt_frames_ok, cnt_drop_err, cnt_drop_ovf, m_ok, m_err, m_ovf);
      end
    end
  end

  // Observed downstream handshakes
  int          frames_out;
  logic [31:0] last_sop_tag;
  logic [1:0]  last_se;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_out = 0; last_sop_tag = 32'hffff_ffff; last_se = 2'b00;
    end else if (out_valid && out_ready) begin
      if (out_sop) last_sop_tag = out_data[31:0];
      if (out_eop) frames_out++;
      last_se = {out_sop, out_eop};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic beat(input int tag, input bit s, input bit e, input logic [ERR_W-1:0] er);
    rx_valid = 1'b1; rx_data = {16{tag}}; rx_sop = s; rx_eop = e; rx_errors = er;
    @(negedge clk);
  endtask

  task automatic frame(input int tag, input int len, input logic [ERR_W-1:0] er);
    for (int i = 0; i < len; i++)
      beat(tag + i, i == 0, i == len - 1, (i == len - 1) ? er : '0);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_errors = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    rx_errors = '0; rx_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out", {out_valid, out_sop, out_eop, out_data[63:0]}, '0);
    chk("reset_cnt", {cnt_frames_ok, cnt_drop_err} | {32'd0, cnt_drop_ovf}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4-beat good frame; first out beat two edges after eop
    frame(0, 4, '0);
    rx_valid = 1'b0;
    chk("latency_edge1_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_edge2_beat", {out_valid, out_sop, out_data[31:0]}, {2'b11, 32'd0});
    idle(6);
    chk("t1_ok", cnt_frames_ok, 1);
    chk("t1_frames_out", frames_out, 1);

    // bad 3-beat frame then good 2-beat frame
    frame(100, 3, 6'h01);
    frame(200, 2, '0);
    idle(6);
    chk("t2_err", cnt_drop_err, 1);
    chk("t2_frames_out", frames_out, 2);
    chk("t2_first_tag", last_sop_tag, 200);

    // overflow with out_ready low; the output register holds one beat so four frames fit
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) frame(300 + 10 * k, 4, '0);
    idle(3);
    chk("t3_ovf", cnt_drop_ovf, 2);
    chk("t3_ok", cnt_frames_ok, 6);
    chk("t3_held_valid", {out_valid, out_data[31:0]}, {1'b1, 32'd300});
    out_ready = 1'b1;
    idle(30);
    chk("t3_frames_out", frames_out, 6);
    chk("t3_last_tag", last_sop_tag, 330);

    // missing eop: new sop restarts
    beat(400, 1, 0, '0);
    beat(401, 0, 0, '0);
    frame(500, 3, '0);
    idle(6);
    chk("t4_err", cnt_drop_err, 2);
    chk("t4_frames_out", frames_out, 7);
    chk("t4_last_tag", last_sop_tag, 500);

    // orphan beats without sop, then a single-beat frame
    beat(600, 0, 0, '0);
    beat(601, 0, 1, '0);
    idle(3);
    chk("t5_err", cnt_drop_err, 3);
    chk("t5_no_out", frames_out, 7);
    frame(700, 1, '0);
    idle(4);
    chk("t5_single_se", last_se, 2'b11);
    chk("t5_single_tag", last_sop_tag, 700);
    chk("t5_ok", cnt_frames_ok, 8);

    // async reset mid-frame with a committed frame pending
    out_ready = 1'b0;
    frame(800, 2, '0);
    beat(900, 1, 0, '0);
    chk("t6_pending_valid", out_valid, 1);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", {cnt_frames_ok, cnt_drop_err} | {32'd0, cnt_drop_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    frame(1000, 3, '0);
    idle(6);
    chk("t6_ok", cnt_frames_ok, 1);
    chk("t6_frames_out", frames_out, 1);
    chk("t6_tag", last_sop_tag, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
